// File: rtl/cmd_issue_queue_pkg.sv
// Types and constants shared by the command issue queue and its bench.
// Widths are taken from the define.sv macros.
// The entry tag field is CMDQ_TAG_W bits; keep TAG_W of the queue equal to it.
`include "define.sv"
package usertype;
    localparam int   CMD_W      = `USER_COMMAND_BITS;
    localparam int   DATA_W     = `DQ_BITS * 8;
    localparam int   RW_BIT     = `CMD_RW_BIT;
    localparam int   RANK_LSB   = `CMD_RANK_LSB;
    localparam int   RANK_MSB   = `CMD_RANK_MSB;
    localparam int   CMDQ_TAG_W = 4;
    localparam logic OP_READ    = 1'b0;

    typedef struct packed {
        logic [CMD_W-1:0]      cmd;
        logic [DATA_W-1:0]     wdata;
        logic [CMDQ_TAG_W-1:0] tag;
    } cmdq_entry_t;

    function automatic logic is_read(input logic [CMD_W-1:0] cmd);
        return cmd[RW_BIT] == OP_READ;
    endfunction
endpackage

// File: rtl/cmd_issue_queue_sync_fifo.sv
// Purpose: single-clock FIFO with full/empty/count, head visible combinationally.
// Latency: a pushed entry is visible at o_pop_dat the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty.
module cmdq_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic [PTR_W-1:0] o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // The extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_full    = (o_count == PTR_W'(DEPTH));
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_pop_dat = r_mem[r_rd_ptr[PTR_W-2:0]];

    // Pointer update; reset flushes the queue by equalising pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    // Storage write; contents need no reset because empty hides them.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PTR_W-2:0]] <= i_push_dat;
    end
endmodule

// File: rtl/define.sv
// Shared width and field macros for the host command path.
// Command layout: [0] r_w, [2:1] rank_num, [USER_COMMAND_BITS-1:3] address.
// Write and read data are DQ_BITS*8 bits wide (one burst).
`ifndef CMDQ_DEFINE_SV
`define CMDQ_DEFINE_SV
`define USER_COMMAND_BITS 16
`define DQ_BITS 8
`define CMD_RW_BIT 0
`define CMD_RANK_LSB 1
`define CMD_RANK_MSB 2
`endif

// File: rtl/cmd_issue_queue.sv
// Purpose: buffer host commands, issue in order, cap outstanding reads, tag read returns.
// Latency: push to pkg_valid 1 cycle; pkg_read_data_valid to rsp_valid 1 cycle.
// Backpressure: host_ready = !cmd_full; head read stalls while MAX_RD reads are outstanding.
// Optional CMDQ_STATS_EN adds saturating 16-bit read/write issue counters.
module cmd_issue_queue
    import usertype::*;
#(
    parameter  int CMD_DEPTH = 8,
    parameter  int MAX_RD    = 8,
    parameter  int TAG_W     = CMDQ_TAG_W,
    localparam int RDC_W     = $clog2(MAX_RD) + 1,
    localparam int CMDC_W    = $clog2(CMD_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              power_on_rst_n,
    input  logic [CMD_W-1:0]  host_cmd,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [TAG_W-1:0]  host_tag,
    input  logic              host_valid,
    output logic              host_ready,
    output logic [CMD_W-1:0]  pkg_command,
    output logic [DATA_W-1:0] pkg_write_data,
    output logic              pkg_valid,
    input  logic              pkg_ready,
    input  logic [DATA_W-1:0] pkg_read_data,
    input  logic              pkg_read_data_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_valid,
    output logic [RDC_W-1:0]  rd_outstanding,
    output logic              err_orphan
`ifdef CMDQ_STATS_EN
    ,
    output logic [15:0]       stat_rd_issued,
    output logic [15:0]       stat_wr_issued
`endif
);
    cmdq_entry_t       w_push_entry;
    cmdq_entry_t       w_head;
    logic              w_cmd_full;
    logic              w_cmd_empty;
    logic [CMDC_W-1:0] w_cmd_count_unused;
    logic              w_host_push;
    logic              w_head_is_read;
    logic              w_issue;
    logic              w_rd_issue;
    logic [TAG_W-1:0]  w_tag_head;
    logic              w_tag_full;
    logic              w_tag_empty;
    logic              w_ret_ok;
    logic              r_rsp_vld;
    logic [DATA_W-1:0] r_rsp_dat;
    logic [TAG_W-1:0]  r_rsp_tag;
    logic              r_err_orphan;

    assign w_push_entry.cmd   = host_cmd;
    assign w_push_entry.wdata = host_wdata;
    assign w_push_entry.tag   = CMDQ_TAG_W'(host_tag);
    assign host_ready         = !w_cmd_full;
    assign w_host_push        = host_valid && !w_cmd_full;

    cmdq_sync_fifo #(.WIDTH($bits(cmdq_entry_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk        (clk),
        .rst_n      (power_on_rst_n),
        .i_push     (w_host_push),
        .i_push_dat (w_push_entry),
        .i_pop      (w_issue),
        .o_pop_dat  (w_head),
        .o_full     (w_cmd_full),
        .o_empty    (w_cmd_empty),
        .o_count    (w_cmd_count_unused)
    );

    // Tag FIFO occupancy is exactly the outstanding-read count, so its full
    // flag is the read-limit stall. Issue only looks at registered state.
    assign w_head_is_read = is_read(w_head.cmd);
    assign pkg_valid      = !w_cmd_empty && (!w_head_is_read || !w_tag_full);
    assign w_issue        = pkg_valid && pkg_ready;
    assign w_rd_issue     = w_issue && w_head_is_read;
    assign pkg_command    = w_cmd_empty ? '0 : w_head.cmd;
    assign pkg_write_data = w_cmd_empty ? '0 : w_head.wdata;

    cmdq_sync_fifo #(.WIDTH(TAG_W), .DEPTH(MAX_RD)) u_tag_fifo (
        .clk        (clk),
        .rst_n      (power_on_rst_n),
        .i_push     (w_rd_issue),
        .i_push_dat (TAG_W'(w_head.tag)),
        .i_pop      (pkg_read_data_valid),
        .o_pop_dat  (w_tag_head),
        .o_full     (w_tag_full),
        .o_empty    (w_tag_empty),
        .o_count    (rd_outstanding)
    );

    // A return with no tag queued is an orphan: no response, only the sticky flag.
    assign w_ret_ok = pkg_read_data_valid && !w_tag_empty;

    // Register each matched return together with the tag of the oldest read.
    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            r_rsp_vld    <= 1'b0;
            r_rsp_dat    <= '0;
            r_rsp_tag    <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_rsp_vld <= w_ret_ok;
            if (w_ret_ok) begin
                r_rsp_dat <= pkg_read_data;
                r_rsp_tag <= w_tag_head;
            end
            if (pkg_read_data_valid && w_tag_empty) r_err_orphan <= 1'b1;
        end
    end

    assign rsp_valid  = r_rsp_vld;
    assign rsp_data   = r_rsp_dat;
    assign rsp_tag    = r_rsp_tag;
    assign err_orphan = r_err_orphan;

`ifdef CMDQ_STATS_EN
    logic [15:0] r_stat_rd;
    logic [15:0] r_stat_wr;

    // Saturating issue counters split by command direction.
    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            r_stat_rd <= '0;
            r_stat_wr <= '0;
        end else begin
            if (w_rd_issue && (r_stat_rd != 16'hFFFF)) r_stat_rd <= r_stat_rd + 16'd1;
            if (w_issue && !w_head_is_read && (r_stat_wr != 16'hFFFF)) r_stat_wr <= r_stat_wr + 16'd1;
        end
    end

    assign stat_rd_issued = r_stat_rd;
    assign stat_wr_issued = r_stat_wr;
`endif
endmodule
